// File: rtl/msg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : msg_write_arbiter
// Description : Shares the single 32-bit message FIFO write port among N_SRC
//               detector message sources. Each message is three words. Sources
//               are served round-robin, one whole message at a time, and only
//               while the FIFO has room for the whole message. Sources cleared
//               in the CPU enable mask get their messages discarded and counted.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1          system clock
//   reset_n     in   1          asynchronous active-low reset
//   req         in   N_SRC      per-source request, held with payload until ack
//   payload     in   N_SRC*96   source i words at [96i+95:96i], w0 in low bits
//   ack         out  N_SRC      one-cycle pulse: message granted or discarded
//   src_en      in   N_SRC      enable mask; 0 = discard that source's messages
//   flush       in   1          synchronous FIFO flush, aborts a message in flight
//   fifo_usedw  in   USEDW_W    current FIFO fill level
//   fifo_data   out  32         word to write
//   fifo_wr     out  1          FIFO write request
//   busy        out  1          high while a message is being written
//   drop_cnt    out  16         saturating count of discarded messages
// ============================================================================
module msg_write_arbiter #(
    parameter int N_SRC      = 4,
    parameter int FIFO_DEPTH = 256,
    parameter int USEDW_W    = 8,
    parameter int MSG_WORDS  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_SRC-1:0]      req,
    input  logic [N_SRC*96-1:0]   payload,
    output logic [N_SRC-1:0]      ack,
    input  logic [N_SRC-1:0]      src_en,
    input  logic                  flush,
    input  logic [USEDW_W-1:0]    fifo_usedw,
    output logic [31:0]           fifo_data,
    output logic                  fifo_wr,
    output logic                  busy,
    output logic [15:0]           drop_cnt
);

    localparam int c_sel_w = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    // A grant is only allowed while the fill level is strictly below this, so
    // a whole message always fits without re-checking mid-message.
    localparam logic [USEDW_W:0] c_room_limit = (USEDW_W + 1)'(FIFO_DEPTH - MSG_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               state_q,     state_d;
    logic [c_sel_w-1:0]   rr_last_q,   rr_last_d;
    logic [63:0]          msg_q,       msg_d;      // w1/w2 of the granted message
    logic [N_SRC-1:0]     ack_q,       ack_d;
    logic                 fifo_wr_q,   fifo_wr_d;
    logic [31:0]          fifo_data_q, fifo_data_d;
    logic                 busy_q,      busy_d;
    logic [15:0]          drop_cnt_q,  drop_cnt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [95:0]          w_payload_arr [N_SRC];
    logic [N_SRC-1:0]     w_elig;
    logic [N_SRC-1:0]     w_discard;
    logic                 w_room;
    logic                 w_grant_found;
    logic [c_sel_w-1:0]   w_grant_idx;
    logic [95:0]          w_grant_msg;
    logic                 w_can_grant;
    logic [16:0]          w_drop_sum;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
            assign w_payload_arr[gi] = payload[gi*96 +: 96];
        end
    endgenerate

    assign w_elig    = req & src_en;
    // The registered ack suppresses a second discard of the same held request
    // on the cycle its ack is visible to the source.
    assign w_discard = req & ~src_en & ~ack_q;
    assign w_room    = ({1'b0, fifo_usedw} < c_room_limit);

    // Round-robin search starting just after the last granted source.
    always_comb begin
        int                 cand;
        logic [c_sel_w-1:0] cand_idx;
        cand          = 0;
        cand_idx      = '0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand     = (int'(rr_last_q) + k) % N_SRC;
            cand_idx = c_sel_w'(cand);
            if (!w_grant_found && w_elig[cand_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = cand_idx;
            end
        end
    end

    assign w_grant_msg = w_payload_arr[w_grant_idx];
    assign w_can_grant = w_grant_found & w_room & ~flush;

    // Several sources may be discarded in one cycle; add them all, then clamp.
    always_comb begin
        w_drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < N_SRC; i++) begin
            w_drop_sum = w_drop_sum + 17'(w_discard[i]);
        end
        drop_cnt_d = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic. Outputs are computed for the
    // state being entered, so fifo_wr/fifo_data/busy line up with the state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        msg_d       = msg_q;
        ack_d       = w_discard;
        fifo_wr_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        busy_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_can_grant) begin
                    state_d              = ST_W0;
                    rr_last_d            = w_grant_idx;
                    msg_d                = w_grant_msg[95:32];
                    ack_d[w_grant_idx]   = 1'b1;
                    fifo_wr_d            = 1'b1;
                    fifo_data_d          = w_grant_msg[31:0];
                    busy_d               = 1'b1;
                end
            end
            ST_W0: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_W1;
                    fifo_wr_d   = 1'b1;
                    fifo_data_d = msg_q[31:0];
                    busy_d      = 1'b1;
                end
            end
            ST_W1: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_W2;
                    fifo_wr_d   = 1'b1;
                    fifo_data_d = msg_q[63:32];
                    busy_d      = 1'b1;
                end
            end
            ST_W2: begin
                // Last word already on the bus; always return to arbitration.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= c_sel_w'(N_SRC - 1);
            msg_q       <= '0;
            ack_q       <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= '0;
            busy_q      <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            msg_q       <= msg_d;
            ack_q       <= ack_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_data_q <= fifo_data_d;
            busy_q      <= busy_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign ack       = ack_q;
    assign fifo_wr   = fifo_wr_q;
    assign fifo_data = fifo_data_q;
    assign busy      = busy_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_msg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_msg_write_arbiter
// Description : Self-checking bench for msg_write_arbiter. Expected FIFO words
//               are queued when stimulus is issued; a monitor pops and compares
//               on every write. Control outputs are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_write_arbiter;

    localparam int N_SRC = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N_SRC-1:0]    req;
    logic [N_SRC*96-1:0] payload;
    logic [N_SRC-1:0]    ack;
    logic [N_SRC-1:0]    src_en;
    logic                flush;
    logic [7:0]          fifo_usedw;
    logic [31:0]         fifo_data;
    logic                fifo_wr;
    logic                busy;
    logic [15:0]         drop_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    msg_write_arbiter #(
        .N_SRC      (N_SRC),
        .FIFO_DEPTH (256),
        .USEDW_W    (8),
        .MSG_WORDS  (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .payload    (payload),
        .ack        (ack),
        .src_en     (src_en),
        .flush      (flush),
        .fifo_usedw (fifo_usedw),
        .fifo_data  (fifo_data),
        .fifo_wr    (fifo_wr),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    // Fixed per-source message words (source 0 uses the reference words).
    function automatic logic [31:0] exp_word(input int s, input int k);
        logic [31:0] r;
        if (s == 0) begin
            case (k)
                0:       r = 32'h00524242;
                1:       r = 32'h00640032;
                default: r = 32'h00C80096;
            endcase
        end else begin
            r = 32'hA000_0000 + 32'(s) * 32'h0100_0000 + 32'(k);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_words(input int s, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(exp_word(s, k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Write monitor: every FIFO write must match the next queued word.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (fifo_wr) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got %h, expected no write", fifo_data);
                end else begin
                    e = exp_q.pop_front();
                    check("fifo_data", fifo_data, e);
                end
            end
        end
    end

    initial begin
        int got [8];
        int ord [5];
        int ng;
        int wr_cnt;
        bit raise0;
        bit reraised;

        ord = '{0, 1, 2, 3, 0};
        reset_n    = 1'b0;
        req        = '0;
        src_en     = 4'b1111;
        flush      = 1'b0;
        fifo_usedw = 8'd0;
        payload    = '0;
        for (int s = 0; s < N_SRC; s++)
            for (int k = 0; k < 3; k++)
                payload[96*s + 32*k +: 32] = exp_word(s, k);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_fifo_wr",   32'(fifo_wr),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_ack",       32'(ack),       32'd0);
        check("rst_fifo_data", fifo_data,      32'd0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'd0);

        // ---------------- 1: single message from source 0 ----------------
        @(negedge clk);
        reset_n = 1'b1;
        req     = 4'b0001;
        push_words(0, 3);
        step();
        check("t1_ack_c1",  32'(ack),     32'h1);
        check("t1_wr_c1",   32'(fifo_wr), 32'd1);
        check("t1_busy_c1", 32'(busy),    32'd1);
        req = '0;
        step();
        check("t1_ack_c2",  32'(ack),  32'h0);
        check("t1_busy_c2", 32'(busy), 32'd1);
        step();
        check("t1_busy_c3", 32'(busy), 32'd1);
        step();
        check("t1_busy_c4", 32'(busy),    32'd0);
        check("t1_wr_c4",   32'(fifo_wr), 32'd0);
        check("t1_hold",    fifo_data,    32'h00C80096);

        // ---------------- 2: round-robin, all sources ----------------
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) push_words(ord[i], 3);
        ng = 0; wr_cnt = 0; raise0 = 0; reraised = 0;
        for (int c = 1; c <= 21; c++) begin
            step();
            if (c <= 16 && fifo_wr) wr_cnt++;
            if (ack != '0) begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (ack[i]) begin
                        if (ng < 8) got[ng] = i;
                        ng++;
                        req[i] = 1'b0;
                        if (i == 0 && !reraised) raise0 = 1;
                    end
                end
            end else if (raise0) begin
                req[0]   = 1'b1;
                raise0   = 0;
                reraised = 1;
            end
        end
        check("t2_grants", 32'(ng), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < ng) check("t2_order", 32'(got[i]), 32'(ord[i]));
        check("t2_wr_per_16", 32'(wr_cnt), 32'd12);

        // ---------------- 3: FIFO room threshold ----------------
        fifo_usedw = 8'd253;
        req        = 4'b0010;
        repeat (3) begin
            step();
            check("t3_no_ack", 32'(ack),     32'h0);
            check("t3_no_wr",  32'(fifo_wr), 32'd0);
        end
        fifo_usedw = 8'd252;
        push_words(1, 3);
        step();
        check("t3_ack", 32'(ack), 32'h2);
        req = '0;
        repeat (3) step();
        fifo_usedw = 8'd0;

        // ---------------- 4: discard and saturation ----------------
        src_en = 4'b1101;
        repeat (3) begin
            req = 4'b0010;
            step();
            check("t4_drop_ack", 32'(ack),     32'h2);
            check("t4_no_wr",    32'(fifo_wr), 32'd0);
            req = '0;
            step();
            check("t4_ack_clr",  32'(ack),     32'h0);
        end
        check("t4_drop3", 32'(drop_cnt), 32'd3);
        // Four masked sources held high: +4 every second edge.
        src_en = 4'b0000;
        req    = 4'b1111;
        repeat (32764) step();
        req = '0;
        check("t4_bulk", 32'(drop_cnt), 32'd65531);
        repeat (3) begin
            req = 4'b0010;
            step();
            req = '0;
            step();
        end
        check("t4_fffe", 32'(drop_cnt), 32'h0000FFFE);
        req = 4'b0010;
        step();
        req = '0;
        step();
        check("t4_sat1", 32'(drop_cnt), 32'h0000FFFF);
        req = 4'b1111;
        step();
        req = '0;
        step();
        check("t4_sat4", 32'(drop_cnt), 32'h0000FFFF);
        src_en = 4'b1111;

        // ---------------- 5: flush mid-message ----------------
        req = 4'b0001;
        push_words(0, 2);
        step();
        check("t5_ack0", 32'(ack), 32'h1);
        req = 4'b0100;
        step();
        check("t5_w1_wr", 32'(fifo_wr), 32'd1);
        flush = 1'b1;
        step();
        check("t5_abort_wr",   32'(fifo_wr), 32'd0);
        check("t5_abort_busy", 32'(busy),    32'd0);
        step();
        check("t5_blocked_ack", 32'(ack),     32'h0);
        check("t5_blocked_wr",  32'(fifo_wr), 32'd0);
        flush = 1'b0;
        push_words(2, 3);
        step();
        check("t5_ack2", 32'(ack), 32'h4);
        req = '0;
        repeat (3) step();
        check("t5_drop_kept", 32'(drop_cnt), 32'h0000FFFF);

        // ---------------- 6: reset mid-message ----------------
        req = 4'b1000;
        push_words(3, 2);
        step();
        check("t6_ack3", 32'(ack), 32'h8);
        req = '0;
        step();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_wr",   32'(fifo_wr),  32'd0);
        check("t6_rst_busy", 32'(busy),     32'd0);
        check("t6_rst_data", fifo_data,     32'd0);
        check("t6_rst_drop", 32'(drop_cnt), 32'd0);
        req = 4'b0101;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        push_words(0, 3);
        push_words(2, 3);
        step();
        check("t6_first_src0", 32'(ack), 32'h1);
        req[0] = 1'b0;
        repeat (3) step();
        step();
        check("t6_then_src2", 32'(ack), 32'h4);
        req = '0;
        repeat (5) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
